// File: rtl/gb_sound_pkg.sv
// gb_sound_pkg: shared constants, tick masks and tick decode for the sound block
package gb_sound_pkg;
   localparam int LEN_MAX_SQ   = 64;
   localparam int LEN_MAX_WAVE = 256;
   localparam int CH_SQ1   = 0;
   localparam int CH_SQ2   = 1;
   localparam int CH_WAVE  = 2;
   localparam int CH_NOISE = 3;
   localparam logic [2:0] STEP_FIRST = 3'd0;
   localparam logic [2:0] STEP_LAST  = 3'd7;
   localparam logic [7:0] TICK_LEN_MASK   = 8'b0101_0101;
   localparam logic [7:0] TICK_SWEEP_MASK = 8'b0100_0100;
   localparam logic [7:0] TICK_ENV_MASK   = 8'b1000_0000;
   typedef struct packed {
      logic len;
      logic sweep;
      logic env;
   } ticks_t;
   function automatic ticks_t tick_decode(input logic [2:0] s);
      return '{len: TICK_LEN_MASK[s], sweep: TICK_SWEEP_MASK[s], env: TICK_ENV_MASK[s]};
   endfunction
endpackage

// File: rtl/length_counter.sv
// length_counter: per-channel length counter and channel-active flag
module length_counter
   import gb_sound_pkg::*;
#(
   parameter int MAX = LEN_MAX_SQ
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       power_on_i,
   input  logic       tick_i,
   input  logic       load_i,
   input  logic       trigger_i,
   input  logic       len_en_i,
   input  logic       dac_on_i,
   input  logic [7:0] data_i,
   output logic       on_o
);
   localparam logic [8:0] MAX_V = 9'(MAX);
   localparam logic [7:0] DMASK = 8'(MAX - 1);
   logic [8:0] cnt_q, cnt_d;
   logic       on_q, on_d, dec;
   // power-off beats load beats trigger beats decrement; dac_on low always kills the flag
   always_comb begin
      dec   = tick_i && len_en_i && cnt_q != '0 && !load_i && !trigger_i;
      cnt_d = !power_on_i ? '0 :
              load_i      ? MAX_V - {1'b0, data_i & DMASK} :
              trigger_i   ? (cnt_q == '0 ? MAX_V : cnt_q) :
              dec         ? cnt_q - 9'd1 : cnt_q;
      on_d  = (!power_on_i || !dac_on_i) ? 1'b0 :
              trigger_i                  ? 1'b1 :
              (dec && cnt_q == 9'd1)     ? 1'b0 : on_q;
   end
   // counter and flag registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         on_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         on_q  <= on_d;
      end
   end
   assign on_o = on_q;
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: frame-rate prescaler, 8-step sequencer, tick strobes and length counters
module frame_sequencer
   import gb_sound_pkg::*;
#(
   parameter int PRESCALE = 8192
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       power_on,
   input  logic [3:0] trigger,
   input  logic [3:0] length_load,
   input  logic [7:0] length_data,
   input  logic [3:0] length_enable,
   input  logic [3:0] dac_on,
   output logic [2:0] step,
   output logic       tick_length,
   output logic       tick_sweep,
   output logic       tick_envelope,
   output logic [3:0] channel_on
);
   localparam int CW = $clog2(PRESCALE);
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    step_q, step_d;
   ticks_t        ticks_q, ticks_d;
   logic          wrap;
   // ticks are decoded from the step being entered so they align with its first cycle
   always_comb begin
      wrap    = power_on && cnt_q == CW'(PRESCALE - 1);
      cnt_d   = (!power_on || wrap) ? '0 : cnt_q + 1'b1;
      step_d  = !power_on ? STEP_LAST : wrap ? step_q + 3'd1 : step_q;
      ticks_d = wrap ? tick_decode(step_d) : '0;
   end
   // prescaler, step and tick registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         step_q  <= STEP_LAST;
         ticks_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         step_q  <= step_d;
         ticks_q <= ticks_d;
      end
   end
   assign step          = step_q;
   assign tick_length   = ticks_q.len;
   assign tick_sweep    = ticks_q.sweep;
   assign tick_envelope = ticks_q.env;
   for (genvar g = 0; g < 4; g++) begin : g_len
      length_counter #(
         .MAX(g == CH_WAVE ? LEN_MAX_WAVE : LEN_MAX_SQ)
      ) u_len (
         .clk       (clk),
         .reset_n   (reset_n),
         .power_on_i(power_on),
         .tick_i    (ticks_q.len),
         .load_i    (length_load[g]),
         .trigger_i (trigger[g]),
         .len_en_i  (length_enable[g]),
         .dac_on_i  (dac_on[g]),
         .data_i    (length_data),
         .on_o      (channel_on[g])
      );
   end
endmodule
